// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and its input conditioner.
// Latency: none, declarations only.
// Backpressure: not applicable.
package timer_pkg;

  // Core clock frequency; every default timing constant is derived from it.
  localparam int CLK_FREQ_HZ = 6_000_000;

  // 10 ms debounce, 0.5 s repeat delay, 0.1 s repeat period.
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;
  localparam int DEFAULT_REPEAT_DELAY    = CLK_FREQ_HZ / 2;
  localparam int DEFAULT_REPEAT_PERIOD   = CLK_FREQ_HZ / 10;

  // Button FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Synchronise one asynchronous pad and accept a new level after DEBOUNCE_CYCLES stable cycles.
// Latency: 2 + DEBOUNCE_CYCLES clocks from raw edge to level; level_next leads level by one cycle.
// Backpressure: none, free-running level output.
module debounce_channel
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic level_next
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser shift, debounce counter and stable-level update.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level      = stable_q;
  assign level_next = stable_d;

endmodule

// File: rtl/timer_input_conditioner.sv
// Clean button/switch pads into an increment pulse (optional auto-repeat) and a run level.
// Latency: 2 + DEBOUNCE_CYCLES clocks per edge; inc_pulse coincides with the first btn_level=1 cycle.
// Backpressure: none; auto-repeat is built only when TIMER_AUTOREPEAT_EN is defined.
module timer_input_conditioner
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  input  logic switch_raw,
  output logic inc_pulse,
  output logic btn_level,
  output logic run_level
);

  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("REPEAT_DELAY must be at least 1");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("REPEAT_PERIOD must be at least 2");
  end

  logic btn_next;
  logic run_next_unused;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk        (clk),
    .rst        (rst),
    .raw        (button_raw),
    .level      (btn_level),
    .level_next (btn_next)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk        (clk),
    .rst        (rst),
    .raw        (switch_raw),
    .level      (run_level),
    .level_next (run_next_unused)
  );

  // The FSM looks at the level the button channel is about to register, so the
  // registered pulse lands in the same cycle btn_level first reads 1, and a
  // release arriving on a fire cycle suppresses that pulse.
  btn_state_t state_q, state_d;
  logic       inc_pulse_q, inc_pulse_d;

`ifdef TIMER_AUTOREPEAT_EN
  localparam int HW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // Next state, hold counter and pulse request.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    inc_pulse_d = 1'b0;
    if (!btn_next) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!btn_level) begin
            inc_pulse_d = 1'b1;
            hold_cnt_d  = '0;
            state_d     = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == DELAY_LAST) begin
            inc_pulse_d = 1'b1;
            hold_cnt_d  = '0;
            state_d     = ST_REPEAT;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (hold_cnt_q == PERIOD_LAST) begin
            inc_pulse_d = 1'b1;
            hold_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // FSM, hold counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      inc_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      inc_pulse_q <= inc_pulse_d;
    end
  end
`else
  // Next state and pulse request; HOLD simply waits for release.
  always_comb begin
    state_d     = state_q;
    inc_pulse_d = 1'b0;
    if (!btn_next) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!btn_level) begin
            inc_pulse_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
        ST_HOLD: state_d = ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inc_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inc_pulse_q <= inc_pulse_d;
    end
  end
`endif

  assign inc_pulse = inc_pulse_q;

endmodule

// File: tb/tb_timer_input_conditioner.sv
// Randomised and directed stimulus against a window-based reference model with a per-cycle scoreboard.
// Latency: expectations are queued one cycle ahead and popped 1 ns after each rising edge.
// Backpressure: none.
module tb_timer_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_raw = 1'b0;
  logic switch_raw = 1'b0;
  logic inc_pulse, btn_level, run_level;

  always #5 clk = ~clk;

  timer_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_raw (button_raw),
    .switch_raw (switch_raw),
    .inc_pulse  (inc_pulse),
    .btn_level  (btn_level),
    .run_level  (run_level)
  );

  typedef struct packed {
    logic inc;
    logic btn;
    logic run;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   dut_pulses = 0;
  int   model_pulses = 0;

  // Reference model: raw history per channel (index 0 = newest sample).
  bit hist [2][0:D+1];
  bit lvl  [2];
  int t;
  int press_t;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k <= D + 1; k++) hist[c][k] = 1'b0;
      lvl[c] = 1'b0;
    end
    t = 0;
    press_t = 0;
  endtask

  // Outputs after the next rising edge, given the raw values sampled there.
  task automatic model_step(input bit b, input bit s, input bit r, output exp_t e);
    bit raws [2];
    bit old_b;
    bit pulse;
    bit all_other;
    e = '0;
    if (r) begin
      model_reset();
      return;
    end
    raws[0] = b;
    raws[1] = s;
    old_b = lvl[0];
    for (int c = 0; c < 2; c++) begin
      for (int k = D + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = raws[c];
      // The synchronised view lags raw by two samples; accept after D agreeing samples.
      all_other = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (hist[c][k] == lvl[c]) all_other = 1'b0;
      if (all_other) lvl[c] = ~lvl[c];
    end
    pulse = 1'b0;
    if (lvl[0] && !old_b) begin
      pulse = 1'b1;
      press_t = t;
    end
`ifdef TIMER_AUTOREPEAT_EN
    else if (lvl[0] && (t - press_t) >= RD && ((t - press_t - RD) % RP) == 0) begin
      pulse = 1'b1;
    end
`endif
    t++;
    e.inc = pulse;
    e.btn = lvl[0];
    e.run = lvl[1];
  endtask

  task automatic cyc(input bit b, input bit s, input bit r);
    exp_t e;
    @(negedge clk);
    button_raw = b;
    switch_raw = s;
    rst = r;
    model_step(b, s, r, e);
    if (e.inc) model_pulses++;
    exp_q.push_back(e);
  endtask

  task automatic hold(input bit b, input bit s, input int n);
    for (int i = 0; i < n; i++) cyc(b, s, 1'b0);
  endtask

  // Monitor: compare every presented output cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (inc_pulse === 1'b1) dut_pulses++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (inc_pulse !== e.inc) begin
          fails++;
          $display("FAIL inc_pulse t=%0t got %b want %b", $time, inc_pulse, e.inc);
        end
        tests++;
        if (btn_level !== e.btn) begin
          fails++;
          $display("FAIL btn_level t=%0t got %b want %b", $time, btn_level, e.btn);
        end
        tests++;
        if (run_level !== e.run) begin
          fails++;
          $display("FAIL run_level t=%0t got %b want %b", $time, run_level, e.run);
        end
      end
    end
  end

  initial begin
    bit b, s;
    model_reset();
    #1;
    tests++;
    if ({inc_pulse, btn_level, run_level} !== 3'b000) begin
      fails++;
      $display("FAIL reset_state got %b want 000", {inc_pulse, btn_level, run_level});
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

    // Clean press held 10 cycles, then release.
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 14);

    // Bounce every 2 cycles for 12 cycles, then settle high.
    for (int i = 0; i < 12; i++) cyc(((i / 2) % 2) == 0, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 16);
    hold(1'b0, 1'b0, 12);

    // Long hold across the repeat schedule.
    hold(1'b1, 1'b0, 60);
    hold(1'b0, 1'b0, 14);

    // Short switch glitch, then a real switch pulse.
    hold(1'b0, 1'b1, 3);
    hold(1'b0, 1'b0, 12);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 12);

    // Reset during REPEAT with the button held, then continue holding.
    hold(1'b1, 1'b0, 35);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 40);
    hold(1'b0, 1'b0, 14);

    // Releases whose debounced fall lands exactly on a repeat-fire cycle.
    hold(1'b1, 1'b0, RD);
    hold(1'b0, 1'b0, 14);
    hold(1'b1, 1'b0, RD + RP);
    hold(1'b0, 1'b0, 14);
    hold(1'b1, 1'b0, 6);
    hold(1'b0, 1'b0, 14);

    // Random chatter, holds and occasional resets.
    b = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) b = ~b;
      if ($urandom_range(0, 11) == 0) s = ~s;
      cyc(b, s, $urandom_range(0, 299) == 0);
    end
    hold(1'b0, 1'b0, 14);

    @(posedge clk);
    #3;
    tests++;
    if (dut_pulses != model_pulses) begin
      fails++;
      $display("FAIL pulse_count got %0d want %0d", dut_pulses, model_pulses);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_input_conditioner.md
# timer_input_conditioner

- Sits directly upstream of the two-digit countdown timer.
- Converts the raw, bouncy `button` and `switch` pad inputs into clean signals for the timer:
  - a single-cycle increment pulse per press, with optional auto-repeat while the button is held;
  - a debounced run level.
- Each input is synchronised and debounced independently, so the timer never sees metastable or chattering levels.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 60000 — consecutive stable cycles required to accept a new level (10 ms at 6 MHz); minimum 2.
- `REPEAT_DELAY`, default 3000000 — hold cycles from the first pulse before auto-repeat starts (0.5 s).
- `REPEAT_PERIOD`, default 600000 — cycles between repeat pulses (0.1 s); minimum 2.

Ports:
- `clk` — input, 1 — single clock; all logic is on its rising edge.
- `rst` — input, 1 — asynchronous, active-high reset.
- `button_raw` — input, 1 — raw push-button pad (ui_in[1]); asynchronous.
- `switch_raw` — input, 1 — raw run switch pad (ui_in[2]); asynchronous.
- `inc_pulse` — output, 1 — one-cycle increment request to the timer.
- `btn_level` — output, 1 — debounced button level.
- `run_level` — output, 1 — debounced switch level; drives the timer's countdown enable.

## Operation

Synchronisation and debounce (both channels):
- Each raw input passes through a 2-flop synchroniser that resets to 0.
- Each channel keeps a `stable` level and a counter.
- Counter clears whenever the synchronised value equals `stable`.
- Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` while still differing, `stable` takes the synchronised value and the counter clears.
- Any glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored, and the counter restarts from zero.
- `btn_level` is the button `stable`; `run_level` is the switch `stable`.

Button FSM (states IDLE, HOLD, REPEAT):
- IDLE: on a `btn_level` 0→1 transition, assert `inc_pulse`, clear the hold counter, go to HOLD.
- HOLD: count up. At `REPEAT_DELAY-1`, assert `inc_pulse`, clear the counter, go to REPEAT.
- REPEAT: count up. At `REPEAT_PERIOD-1`, assert `inc_pulse` and clear the counter.
- From any state, `btn_level`=0 returns to IDLE and clears the counter. No pulse is generated on release.

General rules:
- `inc_pulse` is registered, is never high for two consecutive cycles, and is independent of `run_level`.
- Counter widths are `$clog2(param)`. Counters saturate-free: they always clear on match, so no wrap-around is reachable.

## Timing

- Reset values: `inc_pulse`=0, `btn_level`=0, `run_level`=0, FSM=IDLE, all counters and synchroniser flops 0.
- Press latency: a raw rising edge held clean appears on `btn_level` exactly `2+DEBOUNCE_CYCLES` clocks after the first sampling edge. `inc_pulse` is high in that same first cycle of `btn_level`=1.
- Release latency is identical, `2+DEBOUNCE_CYCLES` clocks.
- First repeat pulse comes `REPEAT_DELAY` cycles after the press pulse. Later pulses are every `REPEAT_PERIOD` cycles.
- Button release in the same cycle a repeat pulse would fire: release wins, no pulse, FSM goes to IDLE.
- Reset mid-hold aborts immediately. A button still held at reset release is treated as a fresh press after `2+DEBOUNCE_CYCLES` clocks and produces one pulse.

## Configuration

Macro: `TIMER_AUTOREPEAT_EN`.
- Defined: HOLD and REPEAT behave as above.
- Undefined:
  - HOLD is a terminal wait-for-release state; REPEAT and its counter are not built.
  - Exactly one `inc_pulse` per debounced press.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are accepted but unused.

## Structure

- Shared package `timer_pkg` holds:
  - the FSM state typedef (IDLE, HOLD, REPEAT);
  - the default timing constants (6 MHz clock frequency, the debounce cycle count, the repeat delay and repeat period).
- The timer block imports the 6 MHz constant from `timer_pkg`.
- One sub-module, `debounce_channel`: synchroniser, counter and `stable` register, parameterised by `DEBOUNCE_CYCLES`. It is instantiated twice, once per input.
- The button FSM lives in the top module.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.

1. Clean press held for 10 cycles, then release → `btn_level` rises 6 cycles after the edge; exactly one `inc_pulse`, in that same cycle; nothing on release.
2. Bounce: raw toggles high/low every 2 cycles for 12 cycles, then stays high → no pulse during bouncing; one pulse 6 cycles after the final rise.
3. Hold for 60 cycles (macro defined) → pulses at press+0, +20, +25, +30, …; none after release. With the macro undefined → exactly one pulse.
4. Switch raw high for 3 cycles, then low → `run_level` stays 0. Switch high for 10 cycles → `run_level` rises 6 cycles after the edge and falls 6 cycles after the raw fall.
5. Assert `rst` during REPEAT with the button still held → all outputs 0 immediately. After release of `rst`, one pulse 6 cycles later, then the repeat schedule restarts from HOLD.
6. Release that lands exactly on a repeat-fire cycle → no pulse, FSM is IDLE the next cycle.
